recip_arbiter: RTL and testbench



---
 rtl/recip_arbiter_if.sv | 28 ++
 rtl/recip_arbiter.sv | 112 +++++++++++
 tb/tb_recip_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/recip_arbiter_if.sv
// rtl/recip_arbiter_if.sv - requester, reciprocal-unit and response bundle for recip_arbiter
// master is the environment side (requesters, reciprocal unit, consumer); slave is the arbiter.
interface recip_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       recip_in;
  logic [DATA_W-1:0]       recip_out;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;

  modport master (
    output req_valid, req_data, recip_out, rsp_ready,
    input  req_ready, recip_in, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, recip_out, rsp_ready,
    output req_ready, recip_in, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/recip_arbiter.sv
// rtl/recip_arbiter.sv - round-robin sharing of one fixed-latency reciprocal unit
// Issues are credit-limited so every in-flight result is guaranteed a slot in the output FIFO.
module recip_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int RECIP_LAT  = 1,
  parameter int FIFO_DEPTH = RECIP_LAT + 2
) (
  input  logic            clk,
  input  logic            rst_n,
  recip_arbiter_if.slave  bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = ID_W + DATA_W;

  logic [ID_W-1:0]  last_grant;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic             issue_ok;
  logic             hs;

  logic [RECIP_LAT-1:0] tag_vld;
  logic [ID_W-1:0]      tag_id [RECIP_LAT];
  logic                 push;
  logic                 pop;

  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [ENT_W-1:0] head;

  // Walk from the requester after last_grant, wrapping at N_REQ (not a power of two in general).
  always_comb begin
    logic [ID_W-1:0] idx;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = (last_grant == ID_W'(N_REQ - 1)) ? '0 : last_grant + 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any   = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
      idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign issue_ok      = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign bus.req_ready = grant & {N_REQ{issue_ok & rst_n}};
  assign hs            = |(bus.req_valid & bus.req_ready);

  assign push = tag_vld[RECIP_LAT-1];
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= ID_W'(N_REQ - 1);
      bus.recip_in <= '0;
      tag_vld      <= '0;
      for (int s = 0; s < RECIP_LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_vld[0] <= hs;
      if (hs) begin
        last_grant   <= grant_id;
        tag_id[0]    <= grant_id;
        bus.recip_in <= bus.req_data[grant_id*DATA_W +: DATA_W];
      end
      for (int s = 1; s < RECIP_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (hs && !push)      inflight <= inflight + 1'b1;
      else if (!hs && push) inflight <= inflight - 1'b1;

      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;

      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers and count clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tag_id[RECIP_LAT-1], bus.recip_out};
  end

  assign head          = mem[rd_ptr];
  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_id    = bus.rsp_valid ? head[ENT_W-1:DATA_W] : '0;
  assign bus.rsp_data  = bus.rsp_valid ? head[DATA_W-1:0] : '0;

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_recip_arbiter.sv
// tb/tb_recip_arbiter.sv - scoreboard bench for recip_arbiter
// Stimulus pushes expected {id, f(operand)} per expected grant; a monitor pops on each response.
module tb_recip_arbiter;
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   rsp_seen = 0;
  int   exp_total = 0;
  int   scnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  recip_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

  recip_arbiter #(.N_REQ(4), .DATA_W(8), .RECIP_LAT(1), .FIFO_DEPTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] f(input logic [7:0] x);
    return (x == 8'h00) ? 8'hFF : 8'(8'd255 / x);
  endfunction

  // Reciprocal unit model with RECIP_LAT=1: result valid the cycle after recip_in updates.
  assign bus.recip_out = f(bus.recip_in);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] v, input logic rr, input logic [3:0] exp_rdy,
                      input logic [7:0] d2 = 8'h00);
    logic [7:0] lane [4];
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      lane[i] = 8'(((scnt * 4 + i) % 15) + 1);
      if (i == 2 && d2 != 8'h00) lane[i] = d2;
      bus.req_data[i*8 +: 8] = lane[i];
    end
    scnt++;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        exp_q.push_back(exp_t'({2'(i), f(lane[i])}));
        exp_total++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_total -= exp_q.size();
    exp_q.delete();
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_recip_in",  32'(bus.recip_in),  32'h0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    @(negedge clk);
    bus.req_valid = 4'h0;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 1'b1, 4'h0);
  endtask

  initial begin : monitor
    exp_t e;
    logic       hold_vld;
    logic [9:0] hold_val;
    hold_vld = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && hold_vld) begin
        chk("rsp_hold_id",   32'(bus.rsp_id),   32'(hold_val[9:8]));
        chk("rsp_hold_data", 32'(bus.rsp_data), 32'(hold_val[7:0]));
      end
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id %0d data %0h expected none at %0t",
                   bus.rsp_id, bus.rsp_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id",   32'(bus.rsp_id),   32'(e.id));
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          rsp_seen++;
        end
      end
      hold_vld = rst_n && bus.rsp_valid && !bus.rsp_ready;
      hold_val = {bus.rsp_id, bus.rsp_data};
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'h0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset, then requester 0 wins the first cycle
    do_reset();
    step(4'hF, 1'b1, 4'b0001);
    drain(4);

    // Single request from requester 2, operand 8'h40, latency 2 cycles
    do_reset();
    step(4'b0100, 1'b1, 4'b0100, 8'h40);
    step(4'h0, 1'b1, 4'h0);
    chk("single_recip_in", 32'(bus.recip_in), 32'h40);
    chk("single_early_valid", 32'(bus.rsp_valid), 32'h0);
    step(4'h0, 1'b1, 4'h0);
    chk("single_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_id", 32'(bus.rsp_id), 32'h2);
    chk("single_data", 32'(bus.rsp_data), 32'h03);
    step(4'h0, 1'b1, 4'h0);
    chk("single_only_one", 32'(bus.rsp_valid), 32'h0);
    drain(2);

    // Fairness: all requesting at full rate
    do_reset();
    for (int j = 0; j < 8; j++) step(4'hF, 1'b1, 4'(1 << (j % 4)));
    drain(4);

    // Backpressure: exactly three issues, then one pop frees one issue
    do_reset();
    step(4'hF, 1'b0, 4'b0001);
    step(4'hF, 1'b0, 4'b0010);
    step(4'hF, 1'b0, 4'b0100);
    step(4'hF, 1'b0, 4'b0000);
    step(4'hF, 1'b0, 4'b0000);
    step(4'hF, 1'b0, 4'b0000);
    step(4'hF, 1'b1, 4'b0000);
    step(4'hF, 1'b0, 4'b1000);
    step(4'hF, 1'b0, 4'b0000);
    drain(6);

    // Sparse fairness: 1 and 3 alternate, then 1 alone
    do_reset();
    step(4'b1010, 1'b1, 4'b0010);
    step(4'b1010, 1'b1, 4'b1000);
    step(4'b1010, 1'b1, 4'b0010);
    step(4'b1010, 1'b1, 4'b1000);
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b0010, 1'b1, 4'b0010);
    drain(4);

    // Mid-operation reset with work in flight and queued
    do_reset();
    step(4'hF, 1'b0, 4'b0001);
    step(4'hF, 1'b0, 4'b0010);
    step(4'hF, 1'b0, 4'b0100);
    do_reset();
    step(4'hF, 1'b1, 4'b0001);
    drain(5);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    chk("rsp_count", 32'(rsp_seen), 32'(exp_total));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
